// File: rtl/vga_update_ctrl_pkg.sv
// ============================================================================
// Module      : vga_update_ctrl_pkg
// Description : Shared board geometry, block encodings and update FSM states
//               for the frame-synchronous vga update scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_update_ctrl_pkg;

    localparam int BITS_PER_BLOCK   = 3;
    localparam int BITS_BLK_POS     = 8;
    localparam int BOARD_WIDTH_BLK  = 10;
    localparam int BOARD_HEIGHT_BLK = 20;
    localparam int BOARD_CELLS      = BOARD_WIDTH_BLK * BOARD_HEIGHT_BLK;

    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY  = '0;
    // Off-board position: never equals a real cell index.
    localparam logic [BITS_BLK_POS-1:0]   BLK_POS_NONE = '1;

    typedef enum logic [1:0] {
        UPD_IDLE     = 2'd0,
        UPD_WAIT_VBL = 2'd1,
        UPD_COMMIT   = 2'd2,
        UPD_DONE     = 2'd3
    } upd_state_e;

    // Board cell index is row*BOARD_WIDTH_BLK + column.
    function automatic logic [BOARD_CELLS-1:0] expand_rows(
        input logic [BOARD_HEIGHT_BLK-1:0] rows
    );
        logic [BOARD_CELLS-1:0] mask;
        mask = '0;
        for (int r = 0; r < BOARD_HEIGHT_BLK; r++) begin
            if (rows[r]) begin
                mask[r*BOARD_WIDTH_BLK +: BOARD_WIDTH_BLK] = '1;
            end
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_update_ctrl_vblank_det.sv
// ============================================================================
// Module      : vga_vblank_det
// Description : Detects the start of vertical blanking (falling vsync) and
//               counts frames since reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_vblank_det #(
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vsync,
    output logic                   vbl_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    logic                   vsync_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    // vsync_q resets high so a low vsync at reset release reads as a new frame.
    assign vbl_start = vsync_q & ~vsync;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vsync_q <= vsync;
            if (vbl_start) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_update_ctrl.sv
// ============================================================================
// Module      : vga_update_ctrl
// Description : Stages game snapshots and commits them to the renderer only
//               at vblank start. Optional row flash under LINE_FLASH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_update_ctrl
    import vga_update_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W = 8
`ifdef LINE_FLASH_EN
    ,
    parameter int FLASH_FRAMES = 6
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef LINE_FLASH_EN
    input  logic                          flash_req,
    input  logic [BOARD_HEIGHT_BLK-1:0]   flash_rows,
    output logic                          flash_done,
`endif
    input  logic                          vsync,
    input  logic                          upd_req,
    output logic                          upd_ack,
    output logic                          upd_busy,
    input  logic [BITS_PER_BLOCK-1:0]     in_ctrl_blk,
    input  logic [4*BITS_BLK_POS-1:0]     in_ctrl_pos,
    input  logic [4*BITS_BLK_POS-1:0]     in_drop_pos,
    input  logic [BOARD_CELLS-1:0]        in_stacked,
    output logic [BITS_PER_BLOCK-1:0]     ctrl_blk,
    output logic [4*BITS_BLK_POS-1:0]     ctrl_pos,
    output logic [4*BITS_BLK_POS-1:0]     drop_pos,
    output logic [BOARD_CELLS-1:0]        stacked_block,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);

    localparam logic [4*BITS_BLK_POS-1:0] POS_NONE4 = {4{BLK_POS_NONE}};

    logic                      vbl_start;
    logic                      upd_blocked;
    logic                      flash_busy;

    upd_state_e                state_q;
    logic                      upd_ack_q;
    logic                      busy_q;

    logic [BITS_PER_BLOCK-1:0] stg_blk_q;
    logic [4*BITS_BLK_POS-1:0] stg_pos_q;
    logic [4*BITS_BLK_POS-1:0] stg_drop_q;
    logic [BOARD_CELLS-1:0]    stg_stacked_q;

    logic [BITS_PER_BLOCK-1:0] ctrl_blk_q;
    logic [4*BITS_BLK_POS-1:0] ctrl_pos_q;
    logic [4*BITS_BLK_POS-1:0] drop_pos_q;
    logic [BOARD_CELLS-1:0]    shown_q;

    vga_vblank_det #(
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_vblank_det (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .vbl_start (vbl_start),
        .frame_cnt (frame_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= UPD_IDLE;
            upd_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
            stg_blk_q     <= '0;
            stg_pos_q     <= '0;
            stg_drop_q    <= '0;
            stg_stacked_q <= '0;
            ctrl_blk_q    <= BLOCK_EMPTY;
            ctrl_pos_q    <= POS_NONE4;
            drop_pos_q    <= POS_NONE4;
            shown_q       <= '0;
        end else begin
            upd_ack_q <= 1'b0;
            case (state_q)
                UPD_IDLE: begin
                    if (upd_req && !upd_blocked) begin
                        stg_blk_q     <= in_ctrl_blk;
                        stg_pos_q     <= in_ctrl_pos;
                        stg_drop_q    <= in_drop_pos;
                        stg_stacked_q <= in_stacked;
                        state_q       <= UPD_WAIT_VBL;
                        busy_q        <= 1'b1;
                    end
                end
                // A vbl_start coinciding with accept is seen in IDLE and ignored,
                // so that snapshot waits a full frame.
                UPD_WAIT_VBL: begin
                    if (vbl_start) begin
                        state_q <= UPD_COMMIT;
                    end
                end
                UPD_COMMIT: begin
                    ctrl_blk_q <= stg_blk_q;
                    ctrl_pos_q <= stg_pos_q;
                    drop_pos_q <= stg_drop_q;
                    shown_q    <= stg_stacked_q;
                    upd_ack_q  <= 1'b1;
                    state_q    <= UPD_DONE;
                end
                UPD_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= UPD_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= UPD_IDLE;
                end
            endcase
        end
    end

    assign upd_ack  = upd_ack_q;
    assign upd_busy = busy_q | flash_busy;
    assign ctrl_blk = ctrl_blk_q;
    assign ctrl_pos = ctrl_pos_q;
    assign drop_pos = drop_pos_q;

`ifdef LINE_FLASH_EN
    localparam int FLASH_CNT_W = $clog2(FLASH_FRAMES + 1);

    logic                        flash_take;
    logic                        flash_act_q;
    logic                        flash_phase_q;
    logic                        flash_done_q;
    logic [BOARD_HEIGHT_BLK-1:0] flash_rows_q;
    logic [FLASH_CNT_W-1:0]      flash_cnt_q;
    logic [BOARD_CELLS-1:0]      stacked_out_q;

    // Flash wins over a simultaneous update request.
    assign flash_take  = (state_q == UPD_IDLE) && flash_req && !flash_act_q;
    assign upd_blocked = flash_take | flash_act_q;
    assign flash_busy  = flash_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_act_q   <= 1'b0;
            flash_phase_q <= 1'b0;
            flash_done_q  <= 1'b0;
            flash_rows_q  <= '0;
            flash_cnt_q   <= '0;
            stacked_out_q <= '0;
        end else begin
            flash_done_q <= 1'b0;
            if (flash_take) begin
                flash_act_q   <= 1'b1;
                flash_phase_q <= 1'b0;
                flash_rows_q  <= flash_rows;
                flash_cnt_q   <= FLASH_CNT_W'(FLASH_FRAMES);
            end else if (flash_act_q && vbl_start) begin
                if (flash_cnt_q <= FLASH_CNT_W'(1)) begin
                    flash_act_q   <= 1'b0;
                    flash_phase_q <= 1'b0;
                    flash_rows_q  <= '0;
                    flash_cnt_q   <= '0;
                    flash_done_q  <= 1'b1;
                end else begin
                    flash_phase_q <= ~flash_phase_q;
                    flash_cnt_q   <= flash_cnt_q - 1'b1;
                end
            end
            stacked_out_q <= flash_phase_q ? (shown_q & ~expand_rows(flash_rows_q))
                                           : shown_q;
        end
    end

    assign flash_done    = flash_done_q;
    assign stacked_block = stacked_out_q;
`else
    assign upd_blocked   = 1'b0;
    assign flash_busy    = 1'b0;
    assign stacked_block = shown_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_update_ctrl.sv
// ============================================================================
// Module      : tb_vga_update_ctrl
// Description : Randomised scoreboard bench for vga_update_ctrl: snapshots
//               must appear two cycles after the first later vblank start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_update_ctrl;
    import vga_update_ctrl_pkg::*;

    localparam int P   = 32;   // frame length in cycles
    localparam int VS0 = 10;   // first low-vsync cycle within a frame
    localparam int VL  = 3;    // vsync low length
    localparam int FCW = 8;
    localparam int PW  = 4 * BITS_BLK_POS;

    typedef struct {
        logic [BITS_PER_BLOCK-1:0] blk;
        logic [PW-1:0]             pos;
        logic [PW-1:0]             drop;
        logic [BOARD_CELLS-1:0]    stk;
        int                        ack_cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      vsync = 1'b1;
    logic                      upd_req = 1'b0;
    logic [BITS_PER_BLOCK-1:0] in_ctrl_blk = '0;
    logic [PW-1:0]             in_ctrl_pos = '0;
    logic [PW-1:0]             in_drop_pos = '0;
    logic [BOARD_CELLS-1:0]    in_stacked = '0;
    logic                      upd_ack;
    logic                      upd_busy;
    logic [BITS_PER_BLOCK-1:0] ctrl_blk;
    logic [PW-1:0]             ctrl_pos;
    logic [PW-1:0]             drop_pos;
    logic [BOARD_CELLS-1:0]    stacked_block;
    logic [FCW-1:0]            frame_cnt;
`ifdef LINE_FLASH_EN
    logic                      flash_req = 1'b0;
    logic [BOARD_HEIGHT_BLK-1:0] flash_rows = '0;
    logic                      flash_done;
`endif

    int   cyc = 0;
    int   bl = -1;
    int   bh = -1;
    bit   done = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    vga_update_ctrl #(.FRAME_CNT_W(FCW)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef LINE_FLASH_EN
        .flash_req     (flash_req),
        .flash_rows    (flash_rows),
        .flash_done    (flash_done),
`endif
        .vsync         (vsync),
        .upd_req       (upd_req),
        .upd_ack       (upd_ack),
        .upd_busy      (upd_busy),
        .in_ctrl_blk   (in_ctrl_blk),
        .in_ctrl_pos   (in_ctrl_pos),
        .in_drop_pos   (in_drop_pos),
        .in_stacked    (in_stacked),
        .ctrl_blk      (ctrl_blk),
        .ctrl_pos      (ctrl_pos),
        .drop_pos      (drop_pos),
        .stacked_block (stacked_block),
        .frame_cnt     (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    // Cycle k begins at the posedge where cyc becomes k.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        vsync = !(((cyc % P) >= VS0) && ((cyc % P) < VS0 + VL));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_snap();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        in_ctrl_blk = BITS_PER_BLOCK'($urandom);
        in_ctrl_pos = $urandom;
        in_drop_pos = $urandom;
        in_stacked  = t[BOARD_CELLS-1:0];
    endtask

    // Raise a request in the current (idle) cycle; the snapshot must show up
    // two cycles after the first vblank start strictly later than accept.
    task automatic issue(input bit do_reset);
        exp_t e;
        int   a;
        int   v;
        int   n;
        a = cyc;
        upd_req = 1'b1;
        e.blk  = in_ctrl_blk;
        e.pos  = in_ctrl_pos;
        e.drop = in_drop_pos;
        e.stk  = in_stacked;
        v = a - (a % P) + VS0;
        if (v <= a) v = v + P;
        e.ack_cyc = v + 2;
        bl = a + 1;
        bh = v + 2;
        sbq.push_back(e);
        tick();
        rand_snap();
        if (do_reset) begin
            tick();
            rst = 1'b1;
            upd_req = 1'b0;
            sbq.delete();
            bh = cyc;
            tick();
            tick();
            rst = 1'b0;
            return;
        end
        n = 0;
        while (upd_ack !== 1'b1 && n < 3 * P) begin
            tick();
            n++;
        end
        upd_req = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        tick();
        while ((cyc % P) != ph) tick();
    endtask

    // Stimulus
    initial begin
        rand_snap();
        repeat (3) tick();
        rst = 1'b0;
        // three idle frames: reset values must hold
        while (cyc < 3 * P + VS0 + 4) tick();
        wait_phase(20);
        rand_snap();
        in_ctrl_pos = {8'd15, 8'd14, 8'd5, 8'd4};
        issue(1'b0);
        // accept coinciding with vblank start
        wait_phase(VS0);
        rand_snap();
        issue(1'b0);
        // reset while waiting for vblank
        wait_phase(VS0 + 5);
        rand_snap();
        issue(1'b1);
        wait_phase(3);
        rand_snap();
        issue(1'b0);
        // long random run, long enough for the frame counter to wrap
        while (cyc < 280 * P) begin
            repeat ($urandom_range(1, 40)) tick();
            rand_snap();
            issue(1'b0);
        end
        repeat (2 * P) tick();
        done = 1'b1;
    end

    task automatic chk(input bit ok, input string name, input string detail);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: %s", name, cyc, detail);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [BITS_PER_BLOCK-1:0] eb;
        logic [PW-1:0]             ep;
        logic [PW-1:0]             ed;
        logic [BOARD_CELLS-1:0]    es;
        int   fc;
        bit   vsd;
        bit   vbl;
        int   c;
        exp_t e;
        eb = BLOCK_EMPTY; ep = '1; ed = '1; es = '0;
        fc = 0;
        vsd = 1'b1;
        @(negedge clk);
        while (!done) begin
            c = cyc;
            if (c >= 1) begin
                chk(frame_cnt === FCW'(fc), "frame_cnt",
                    $sformatf("got %0d want %0d", frame_cnt, FCW'(fc)));
                chk(upd_busy === ((c >= bl) && (c <= bh)), "upd_busy",
                    $sformatf("got %b want %b", upd_busy, ((c >= bl) && (c <= bh))));
                if (upd_ack === 1'b1) begin
                    if (sbq.size() == 0) begin
                        chk(1'b0, "unexpected_ack", "got ack=1 want ack=0");
                    end else begin
                        e = sbq.pop_front();
                        chk(c == e.ack_cyc, "ack_cycle",
                            $sformatf("got cycle %0d want cycle %0d", c, e.ack_cyc));
                        eb = e.blk; ep = e.pos; ed = e.drop; es = e.stk;
                    end
                end else if (upd_ack !== 1'b0) begin
                    chk(1'b0, "ack_x", $sformatf("got %b want 0/1", upd_ack));
                end else if (sbq.size() > 0 && sbq[0].ack_cyc <= c) begin
                    e = sbq.pop_front();
                    chk(1'b0, "missing_ack", $sformatf("got no ack want ack at %0d", e.ack_cyc));
                    eb = e.blk; ep = e.pos; ed = e.drop; es = e.stk;
                end
                chk((ctrl_blk === eb) && (ctrl_pos === ep) && (drop_pos === ed)
                    && (stacked_block === es), "shown",
                    $sformatf("got blk=%h pos=%h drop=%h stk=%h want blk=%h pos=%h drop=%h stk=%h",
                              ctrl_blk, ctrl_pos, drop_pos, stacked_block, eb, ep, ed, es));
            end
            vbl = vsd && !vsync;
            if (rst) begin
                fc = 0;
                vsd = 1'b1;
                eb = BLOCK_EMPTY; ep = '1; ed = '1; es = '0;
            end else begin
                if (vbl) fc++;
                vsd = vsync;
            end
            @(negedge clk);
        end
        chk(sbq.size() == 0, "pending_updates",
            $sformatf("got %0d outstanding want 0", sbq.size()));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
